upsample_stream: RTL

Streaming nearest-neighbour upsampler: the inverse-direction counterpart of the max-pooling stage. It accepts a pooled feature map of IN_W×IN_W pixels in raster order and emits an (IN_W·UP)×(IN_W·UP) map in which every input pixel is replicated into an UP×UP block. It sits on the YOLO upsample path, between a pooled or reduced layer and the concatenation or convolution stage that needs the original spatial resolution. It buffers one input row, so the block needs no frame memory.

---
 rtl/yolo_params_pkg.sv | 19 +
 rtl/upsample_line_buf.sv | 24 ++
 rtl/upsample_stream.sv | 127 ++++++++++++
 3 files changed

// File: rtl/yolo_params_pkg.sv
// Shared YOLO datapath parameters and upsampler state encoding.
package yolo_params_pkg;

  localparam int unsigned RESULT_WIDTH    = 13;
  localparam int unsigned POOL_STRIDE     = 2;
  localparam int unsigned IP_DATA_WIDTH   = 15;
  localparam int unsigned UPSAMPLE_FACTOR = POOL_STRIDE;

  typedef enum logic {
    US_LOAD = 1'b0,
    US_EMIT = 1'b1
  } upsample_state_t;

  // Counter width for a 0..range-1 counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// One-row pixel store: synchronous write port, combinational read port.
module upsample_line_buf #(
  parameter int unsigned IN_W   = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [IN_W];

  // Row storage; contents are always written before they are read, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/upsample_stream.sv
// Streaming nearest-neighbour upsampler: buffers one input row and replays it
// UP times, repeating each pixel UP times along the row.
module upsample_stream
  import yolo_params_pkg::*;
#(
  parameter int unsigned IN_W   = RESULT_WIDTH,
  parameter int unsigned UP     = UPSAMPLE_FACTOR,
  parameter int unsigned DATA_W = IP_DATA_WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned COL_W = cnt_width(IN_W);
  localparam int unsigned REP_W = cnt_width(UP);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IN_W - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(UP - 1);

  upsample_state_t  state, state_n;
  logic [COL_W-1:0] in_col, in_col_n;
  logic [COL_W-1:0] col_idx, col_idx_n;
  logic [COL_W-1:0] in_row, in_row_n;
  logic [REP_W-1:0] rep_col, rep_col_n;
  logic [REP_W-1:0] rep_row, rep_row_n;
  logic             out_last_n;
  logic             buf_we_c;
  logic             in_beat_c;
  logic             out_beat_c;

  assign in_beat_c  = in_valid && in_ready;
  assign out_beat_c = out_valid && out_ready;

  upsample_line_buf #(
    .IN_W  (IN_W),
    .DATA_W(DATA_W),
    .ADDR_W(COL_W)
  ) u_line_buf (
    .clk  (clk),
    .we   (buf_we_c),
    .waddr(in_col),
    .wdata(in_data),
    .raddr(col_idx),
    .rdata(out_data)
  );

  // Next-state and counter update: fill the row in LOAD, replay it in EMIT.
  always_comb begin
    state_n   = state;
    in_col_n  = in_col;
    col_idx_n = col_idx;
    in_row_n  = in_row;
    rep_col_n = rep_col;
    rep_row_n = rep_row;
    buf_we_c  = 1'b0;
    case (state)
      US_LOAD: begin
        if (in_beat_c) begin
          buf_we_c = 1'b1;
          if (in_col == COL_MAX) begin
            in_col_n = '0;
            state_n  = US_EMIT;
          end else begin
            in_col_n = in_col + COL_W'(1);
          end
        end
      end
      US_EMIT: begin
        if (out_beat_c) begin
          if (rep_col != REP_MAX) begin
            rep_col_n = rep_col + REP_W'(1);
          end else begin
            rep_col_n = '0;
            if (col_idx != COL_MAX) begin
              col_idx_n = col_idx + COL_W'(1);
            end else begin
              col_idx_n = '0;
              if (rep_row != REP_MAX) begin
                rep_row_n = rep_row + REP_W'(1);
              end else begin
                rep_row_n = '0;
                in_row_n  = (in_row == COL_MAX) ? '0 : in_row + COL_W'(1);
                state_n   = US_LOAD;
              end
            end
          end
        end
      end
      default: state_n = US_LOAD;
    endcase
    out_last_n = (state_n == US_EMIT) && (rep_row_n == REP_MAX) &&
                 (col_idx_n == COL_MAX) && (rep_col_n == REP_MAX) &&
                 (in_row_n == COL_MAX);
  end

  // State, counters and handshake flags; handshakes are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= US_LOAD;
      in_col    <= '0;
      col_idx   <= '0;
      in_row    <= '0;
      rep_col   <= '0;
      rep_row   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      in_col    <= in_col_n;
      col_idx   <= col_idx_n;
      in_row    <= in_row_n;
      rep_col   <= rep_col_n;
      rep_row   <= rep_row_n;
      in_ready  <= (state_n == US_LOAD);
      out_valid <= (state_n == US_EMIT);
      out_last  <= out_last_n;
    end
  end

endmodule
